elevator_scan_ctrl: RTL and testbench
=====================================

# elevator_scan_ctrl

Parametrised elevator car controller for N floors: latches hall/car call buttons, moves the car one floor per travel interval using a SCAN (keep-direction) policy, and holds the door open for a fixed interval at each served floor. It is the next-generation replacement for the fixed three-floor movement controller. It drives the request LEDs, floor indicators and door/moving status outputs directly.

## Interface

Parameters:
- NUM_FLOORS, 3, number of floors (≥2); floor 0 is the ground floor.
- FLOOR_W, $clog2(NUM_FLOORS), width of the floor index.
- TRAVEL_CYCLES, 4, clock cycles to travel one floor (≥1).
- DOOR_CYCLES, 3, clock cycles the door stays open (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- call_btn  in  NUM_FLOORS  call request per floor, level, already synchronised.
- req_led  out  NUM_FLOORS  pending-request indicator per floor.
- floor_onehot  out  NUM_FLOORS  one-hot current floor.
- cur_floor  out  FLOOR_W  binary current floor.
- door_open  out  1  door open.
- moving  out  1  car travelling between floors.
- dir_up  out  1  current scan direction (1 = up).

## Operation

- Reset values: req_led=0, cur_floor=0, floor_onehot=1, door_open=0, moving=0, dir_up=1, state IDLE, counters 0.
- Request bank: bit i is set on any clock where call_btn[i]=1, except when the car is at floor i in IDLE or DOOR. It is cleared on entry to DOOR at floor i. Set and clear on the same edge: clear wins.
- Pressing the current floor's button in IDLE opens the door (IDLE→DOOR) without latching the request. Pressing it during DOOR restarts the door counter.
- States:
  - IDLE: door closed, not moving.
  - MOVE: moving=1, travel counter runs.
  - DOOR: door_open=1, door counter runs.
- Direction decision, evaluated in IDLE and at DOOR expiry:
  - Requests ahead in dir_up direction: stay in that direction, go to MOVE.
  - Else requests behind: toggle dir_up, go to MOVE.
  - Else: go to IDLE, keeping dir_up.
- MOVE step: when the travel counter reaches TRAVEL_CYCLES-1, cur_floor moves ±1 per dir_up and the counter resets.
  - If the new floor has a pending request: enter DOOR and clear its bit.
  - Otherwise stay in MOVE; the direction is re-evaluated at each floor by the same rule.
- Boundaries:
  - Floor 0 and NUM_FLOORS-1 are never passed. At a terminal floor the "ahead" set is empty, so the direction reverses.
  - Requests latched mid-travel for the floor just left are served on the return sweep.
  - No request pending anywhere → IDLE.
- Reset asserted mid-travel or with the door open returns to floor 0 immediately (asynchronous), with the door closed and all requests cleared.

## Timing

- call_btn sampled at edge t → req_led visible after edge t.
- IDLE with a pending remote request → moving=1 after the next edge.
- Each floor takes exactly TRAVEL_CYCLES cycles in MOVE. cur_floor, floor_onehot and door_open (on arrival) update on the same edge.
- door_open stays high exactly DOOR_CYCLES cycles, then next state MOVE/IDLE is entered on the following edge with door_open=0.
- All outputs are registered. No combinational path from call_btn to any output.

## Structure

- Shared package elevator_pkg: state enum (IDLE, MOVE, DOOR) and direction constants (DIR_UP, DIR_DOWN).
- Sub-module elev_req_bank: request register with set/clear and the "any above / any below / at floor" reductions relative to cur_floor.
- Top level contains the FSM, travel/door counters and the floor register. floor_onehot is decoded from the registered cur_floor register.

## Test plan

NUM_FLOORS=4, TRAVEL_CYCLES=4, DOOR_CYCLES=3; cycle 0 is the first edge after reset release.
- call_btn[2] pulsed at cycle 0 → req_led[2]=1 after edge 0; moving=1 after edge 1; cur_floor=1 after edge 5; cur_floor=2 and door_open=1 after edge 9; req_led[2]=0; door_open=0 after edge 12; IDLE.
- call_btn[0] pressed while idle at floor 0 → door_open=1 next edge, req_led[0] stays 0. Pressing again during DOOR extends the open time by 3 cycles from that press.
- At floor 1 going up, requests latched at floors 3 and 0 → car serves floor 3 first, then reverses (dir_up=0) and serves floor 0.
- Car in MOVE from 0 to 3, call_btn[1] latched before arrival at floor 1 → stops at floor 1 (door 3 cycles), then continues to 3.
- rst_n asserted asynchronously mid-travel between floors 2 and 3 with door requests pending → all outputs at reset values immediately. After release, the car stays IDLE with no spontaneous movement.
- Request for floor 3 held at terminal floor 3 while moving down from 3 → not latched. A later request for floor 3 after departure is served on the next up-sweep.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types for the elevator SCAN controller: FSM state encoding and
// scan direction constants.
package elevator_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MOVE = 2'd1,
      DOOR = 2'd2
   } state_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/elev_req_bank.sv
// Latched call requests, one bit per floor, with above/below/at reductions
// taken relative to a caller-supplied reference floor.
module elev_req_bank
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = 3,
   parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_FLOORS-1:0] set_mask,
   input  logic [NUM_FLOORS-1:0] clr_mask,
   input  logic [FLOOR_W-1:0]    ref_floor,
   output logic [NUM_FLOORS-1:0] req,
   output logic                  any_above,
   output logic                  any_below,
   output logic                  at_floor
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) req <= '0;
      else        req <= (req | set_mask) & ~clr_mask;
   end

   always_comb begin
      any_above = 1'b0;
      any_below = 1'b0;
      at_floor  = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (FLOOR_W'(i) > ref_floor)  any_above = any_above | req[i];
         if (FLOOR_W'(i) < ref_floor)  any_below = any_below | req[i];
         if (FLOOR_W'(i) == ref_floor) at_floor  = at_floor  | req[i];
      end
   end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN elevator car controller: one floor per travel interval, keeps its
// direction while requests remain ahead, holds the door at served floors.
//
// state | meaning
// IDLE  | door closed, car parked, waiting for a request
// MOVE  | travelling; travel timer counts down to the next floor
// DOOR  | door open at cur_floor; door timer counts down
module elevator_scan_ctrl
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS    = 3,
   parameter int FLOOR_W       = $clog2(NUM_FLOORS),
   parameter int TRAVEL_CYCLES = 4,
   parameter int DOOR_CYCLES   = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_FLOORS-1:0] call_btn,
   output logic [NUM_FLOORS-1:0] req_led,
   output logic [NUM_FLOORS-1:0] floor_onehot,
   output logic [FLOOR_W-1:0]    cur_floor,
   output logic                  door_open,
   output logic                  moving,
   output logic                  dir_up
);

   localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);

   state_t                  state;
   logic [CNT_W-1:0]        travel_cnt;
   logic [CNT_W-1:0]        door_cnt;
   logic [FLOOR_W-1:0]      next_floor;
   logic [FLOOR_W-1:0]      ref_floor;
   logic [NUM_FLOORS-1:0]   cur_mask;
   logic [NUM_FLOORS-1:0]   ref_mask;
   logic [NUM_FLOORS-1:0]   req_set;
   logic [NUM_FLOORS-1:0]   req_clr;
   logic                    travel_done;
   logic                    cur_btn;
   logic                    enter_door;
   logic                    ahead;
   logic                    behind;
   logic                    any_above;
   logic                    any_below;
   logic                    at_floor;

   // On an arrival edge the reductions look at the floor being entered,
   // so the stop/continue/reverse choice is made for the new floor.
   always_comb begin
      travel_done = (state == MOVE) && (travel_cnt == '0);
      next_floor  = (dir_up == DIR_UP) ? cur_floor + FLOOR_W'(1) : cur_floor - FLOOR_W'(1);
      ref_floor   = travel_done ? next_floor : cur_floor;
      cur_mask    = '0;
      ref_mask    = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         cur_mask[i] = (cur_floor == FLOOR_W'(i));
         ref_mask[i] = (ref_floor == FLOOR_W'(i));
      end
      cur_btn    = |(call_btn & cur_mask);
      ahead      = (dir_up == DIR_UP) ? any_above : any_below;
      behind     = (dir_up == DIR_UP) ? any_below : any_above;
      enter_door = ((state == IDLE) && (cur_btn || at_floor)) || (travel_done && at_floor);
      req_set    = (state == MOVE) ? call_btn : (call_btn & ~cur_mask);
      req_clr    = enter_door ? ref_mask : '0;
   end

   elev_req_bank #(
      .NUM_FLOORS (NUM_FLOORS),
      .FLOOR_W    (FLOOR_W)
   ) u_req_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .set_mask  (req_set),
      .clr_mask  (req_clr),
      .ref_floor (ref_floor),
      .req       (req_led),
      .any_above (any_above),
      .any_below (any_below),
      .at_floor  (at_floor)
   );

   assign floor_onehot = cur_mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cur_floor  <= '0;
         dir_up     <= DIR_UP;
         door_open  <= 1'b0;
         moving     <= 1'b0;
         travel_cnt <= '0;
         door_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (enter_door) begin
                  state     <= DOOR;
                  door_open <= 1'b1;
                  door_cnt  <= DOOR_LOAD;
               end else if (ahead || behind) begin
                  state      <= MOVE;
                  moving     <= 1'b1;
                  travel_cnt <= TRAVEL_LOAD;
                  if (!ahead) dir_up <= ~dir_up;
               end
            end
            MOVE: begin
               if (travel_done) begin
                  cur_floor  <= next_floor;
                  travel_cnt <= TRAVEL_LOAD;
                  if (at_floor) begin
                     state     <= DOOR;
                     moving    <= 1'b0;
                     door_open <= 1'b1;
                     door_cnt  <= DOOR_LOAD;
                  end else if (behind && !ahead) begin
                     dir_up <= ~dir_up;
                  end else if (!ahead) begin
                     state  <= IDLE;
                     moving <= 1'b0;
                  end
               end else begin
                  travel_cnt <= travel_cnt - CNT_W'(1);
               end
            end
            DOOR: begin
               if (cur_btn) begin
                  door_cnt <= DOOR_LOAD;
               end else if (door_cnt == '0) begin
                  door_open <= 1'b0;
                  if (ahead || behind) begin
                     state      <= MOVE;
                     moving     <= 1'b1;
                     travel_cnt <= TRAVEL_LOAD;
                     if (!ahead) dir_up <= ~dir_up;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  door_cnt <= door_cnt - CNT_W'(1);
               end
            end
            default: begin
               state     <= IDLE;
               door_open <= 1'b0;
               moving    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Self-checking bench for elevator_scan_ctrl with 4 floors, 4-cycle travel
// and 3-cycle door time.
module tb_elevator_scan_ctrl;

   localparam int N  = 4;
   localparam int FW = 2;

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  call_btn;
   logic [N-1:0]  req_led;
   logic [N-1:0]  floor_onehot;
   logic [FW-1:0] cur_floor;
   logic          door_open;
   logic          moving;
   logic          dir_up;

   int n_vec = 0;
   int n_err = 0;

   elevator_scan_ctrl #(
      .NUM_FLOORS    (N),
      .FLOOR_W       (FW),
      .TRAVEL_CYCLES (4),
      .DOOR_CYCLES   (3)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .call_btn     (call_btn),
      .req_led      (req_led),
      .floor_onehot (floor_onehot),
      .cur_floor    (cur_floor),
      .door_open    (door_open),
      .moving       (moving),
      .dir_up       (dir_up)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]  btn;
      logic [N-1:0]  req;
      logic [FW-1:0] floor;
      logic          door;
      logic          mov;
   } vec_t;

   vec_t tbl[14];
   vec_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      call_btn = '0;
      rst_n    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_reset_vals(input string name);
      chk({name, "_out"}, {req_led, floor_onehot, 2'(cur_floor), door_open, moving, dir_up},
          {4'b0000, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b1});
   endtask

   task automatic wait_door(input logic [FW-1:0] f, input string name);
      int n = 0;
      while (door_open && n < 300) begin step(); n++; end
      while (!door_open && n < 300) begin step(); n++; end
      if (n >= 300) chk({name, "_timeout"}, 32'd1, 32'd0);
      else          chk({name, "_floor"}, 32'(cur_floor), 32'(f));
   endtask

   task automatic wait_close(input string name);
      int n = 0;
      while (door_open && n < 50) begin step(); n++; end
      if (n >= 50) chk({name, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic wait_floor(input logic [FW-1:0] f, input string name);
      int n = 0;
      while (cur_floor != f && n < 300) begin step(); n++; end
      if (n >= 300) chk({name, "_timeout"}, 32'd1, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t e;
      int   mov_seen;

      // basic trip 0 -> 2, rows are the state after each edge
      tbl[0]  = '{4'b0100, 4'b0100, 2'd0, 1'b0, 1'b0};
      tbl[1]  = '{4'b0000, 4'b0100, 2'd0, 1'b0, 1'b1};
      tbl[2]  = '{4'b0000, 4'b0100, 2'd0, 1'b0, 1'b1};
      tbl[3]  = '{4'b0000, 4'b0100, 2'd0, 1'b0, 1'b1};
      tbl[4]  = '{4'b0000, 4'b0100, 2'd0, 1'b0, 1'b1};
      tbl[5]  = '{4'b0000, 4'b0100, 2'd1, 1'b0, 1'b1};
      tbl[6]  = '{4'b0000, 4'b0100, 2'd1, 1'b0, 1'b1};
      tbl[7]  = '{4'b0000, 4'b0100, 2'd1, 1'b0, 1'b1};
      tbl[8]  = '{4'b0000, 4'b0100, 2'd1, 1'b0, 1'b1};
      tbl[9]  = '{4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0};
      tbl[10] = '{4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0};
      tbl[11] = '{4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0};
      tbl[12] = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
      tbl[13] = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};

      do_reset();
      check_reset_vals("reset");

      for (int k = 0; k < 14; k++) begin
         call_btn = tbl[k].btn;
         sb.push_back(tbl[k]);
         step();
         e = sb.pop_front();
         chk($sformatf("trip_vec%0d", k),
             {req_led, floor_onehot, 2'(cur_floor), door_open, moving},
             {e.req, 4'(1 << e.floor), 2'(e.floor), e.door, e.mov});
      end
      call_btn = '0;

      // own-floor button opens the door, a second press extends it
      do_reset();
      call_btn = 4'b0001; step();
      chk("own_open", {door_open, moving}, 2'b10);
      chk("own_noreq", 32'(req_led), 32'd0);
      call_btn = 4'b0000; step();
      call_btn = 4'b0001; step();
      call_btn = 4'b0000; step(); step();
      chk("own_extended", {door_open, req_led}, {1'b1, 4'b0000});
      step();
      chk("own_closed", {door_open, moving}, 2'b00);

      // floor 1 going up with requests at 3 and 0: serve 3, reverse, serve 0
      do_reset();
      call_btn = 4'b1000; step();
      call_btn = 4'b0000; repeat (5) step();
      chk("scan_at1", {2'(cur_floor), moving, dir_up}, {2'd1, 1'b1, 1'b1});
      call_btn = 4'b0001; step();
      call_btn = 4'b0000;
      chk("scan_req", 32'(req_led), 32'b1001);
      wait_door(2'd3, "scan_first3");
      chk("scan_req_after3", 32'(req_led), 32'b0001);
      wait_close("scan_close3");
      chk("scan_reverse", {dir_up, moving}, 2'b01);
      wait_door(2'd0, "scan_then0");
      chk("scan_done", {req_led, dir_up}, {4'b0000, 1'b0});

      // intermediate stop at floor 1 on the way to 3
      do_reset();
      call_btn = 4'b1000; step();
      call_btn = 4'b0000; step(); step();
      call_btn = 4'b0010; step();
      call_btn = 4'b0000;
      chk("mid_req", 32'(req_led), 32'b1010);
      step(); step();
      chk("mid_stop1", {2'(cur_floor), door_open, moving, req_led}, {2'd1, 1'b1, 1'b0, 4'b1000});
      step(); step();
      chk("mid_door_hold", 32'(door_open), 32'd1);
      step();
      chk("mid_depart", {door_open, moving, dir_up}, 3'b011);
      wait_door(2'd3, "mid_reach3");

      // asynchronous reset mid-travel between 2 and 3 with requests pending
      do_reset();
      call_btn = 4'b1000; step();
      call_btn = 4'b0000; repeat (5) step();
      call_btn = 4'b0001; step();
      call_btn = 4'b0000; repeat (5) step();
      chk("rst_pre", {2'(cur_floor), moving, req_led}, {2'd2, 1'b1, 4'b1001});
      #2 rst_n = 1'b0;
      #1 check_reset_vals("async_rst");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      mov_seen = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (moving || door_open || cur_floor != 2'd0) mov_seen++;
      end
      chk("rst_no_spont", 32'(mov_seen), 32'd0);

      // terminal floor 3: own press is not latched, later press is served upward
      do_reset();
      call_btn = 4'b1000; step();
      call_btn = 4'b0000; repeat (5) step();
      call_btn = 4'b0001; step();
      call_btn = 4'b0000;
      wait_door(2'd3, "term_reach3");
      call_btn = 4'b1000; step();
      call_btn = 4'b0000;
      chk("term_not_latched", 32'(req_led), 32'b0001);
      wait_close("term_close");
      chk("term_down", {dir_up, moving}, 2'b01);
      wait_floor(2'd2, "term_at2");
      call_btn = 4'b1000; step();
      call_btn = 4'b0000;
      chk("term_relatch", 32'(req_led), 32'b1001);
      wait_door(2'd0, "term_serve0");
      wait_door(2'd3, "term_serve3");
      chk("term_up_again", {dir_up, req_led}, {1'b1, 4'b0000});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
